// File: rtl/i2cresponder.sv
`timescale 1ns/1ps
// I2C target serving an NREG-byte register bank at 7-bit address ADDR, also host read/write.
// Latency: sdao and wrpulse move 3 CLOCKs after the scli edge (2 sync stages + 1 register).
// Backpressure: none; no clock stretching, host writes always land (I2C wins on collision).
module i2cresponder #(
  parameter logic [6:0] ADDR   = 7'h20,
  parameter int         NREGL2 = 3
) (
  input  logic              CLOCK,
  input  logic              RESET,
  input  logic              scli,
  input  logic              sdai,
  output logic              sdao,
  input  logic [NREGL2-1:0] hostidx,
  output logic [7:0]        hostrdata,
  input  logic              hostwrite,
  input  logic [7:0]        hostwdata,
  output logic              wrpulse,
  output logic [NREGL2-1:0] wrindex,
  output logic              busy,
  output logic [2:0]        state
);
  localparam int NREG = 1 << NREGL2;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_ADDR    = 3'd1,
    S_ADDRACK = 3'd2,
    S_WRBYTE  = 3'd3,
    S_WRACK   = 3'd4,
    S_RDBYTE  = 3'd5,
    S_RDACK   = 3'd6,
    S_IGNORE  = 3'd7
  } state_t;

  state_t            st;
  logic              scl_m, scls, scl_q;
  logic              sda_m, sdas, sda_q;
  logic              scl_rise, scl_fall, start_det, stop_det;
  logic [7:0]        shift;
  logic [7:0]        txbyte;
  logic [3:0]        bitcnt;
  logic [NREGL2-1:0] ptr;
  logic              rw, first, mack;
  logic [7:0]        bank [NREG];

  assign state     = st;
  assign hostrdata = bank[hostidx];

  // Two-flop synchronizers plus one cycle of history; left out of RESET so edge
  // history stays consistent with the bus and no phantom START/STOP appears after reset.
  always_ff @(posedge CLOCK) begin
    scl_m <= scli;
    scls  <= scl_m;
    scl_q <= scls;
    sda_m <= sdai;
    sdas  <= sda_m;
    sda_q <= sdas;
  end

  assign scl_rise  = scls & ~scl_q;
  assign scl_fall  = ~scls & scl_q;
  assign start_det = scls & scl_q & sda_q & ~sdas;
  assign stop_det  = scls & scl_q & ~sda_q & sdas;

  // Protocol FSM, bank storage and all registered outputs; START/STOP pre-empt bit handling.
  always_ff @(posedge CLOCK) begin
    if (RESET) begin
      st      <= S_IDLE;
      sdao    <= 1'b1;
      busy    <= 1'b0;
      wrpulse <= 1'b0;
      wrindex <= '0;
      ptr     <= '0;
      first   <= 1'b0;
      shift   <= '0;
      txbyte  <= '0;
      bitcnt  <= '0;
      rw      <= 1'b0;
      mack    <= 1'b1;
      for (int i = 0; i < NREG; i++) bank[i] <= '0;
    end else begin
      wrpulse <= 1'b0;
      // host write first so a same-cycle I2C commit to the same index overrides it
      if (hostwrite) bank[hostidx] <= hostwdata;
      if (start_det) begin
        st     <= S_ADDR;
        shift  <= '0;
        bitcnt <= '0;
        sdao   <= 1'b1;
        busy   <= 1'b0;
      end else if (stop_det) begin
        st   <= S_IDLE;
        sdao <= 1'b1;
        busy <= 1'b0;
      end else begin
        case (st)
          S_ADDR: begin
            if (scl_rise) begin
              shift  <= {shift[6:0], sdas};
              bitcnt <= bitcnt + 4'd1;
            end else if (scl_fall && bitcnt == 4'd8) begin
              if (shift[7:1] == ADDR && shift[7:1] != 7'd0) begin
                sdao <= 1'b0;
                rw   <= shift[0];
                busy <= 1'b1;
                st   <= S_ADDRACK;
              end else begin
                st <= S_IGNORE;
              end
            end
          end
          S_ADDRACK: begin
            if (scl_fall) begin
              bitcnt <= '0;
              shift  <= '0;
              if (!rw) begin
                sdao  <= 1'b1;
                first <= 1'b1;
                st    <= S_WRBYTE;
              end else begin
                txbyte <= bank[ptr];
                sdao   <= bank[ptr][7];
                ptr    <= ptr + 1'b1;
                st     <= S_RDBYTE;
              end
            end
          end
          S_WRBYTE: begin
            if (scl_rise) begin
              shift  <= {shift[6:0], sdas};
              bitcnt <= bitcnt + 4'd1;
            end else if (scl_fall && bitcnt == 4'd8) begin
              sdao   <= 1'b0;
              bitcnt <= '0;
              st     <= S_WRACK;
              if (first) begin
                ptr   <= shift[NREGL2-1:0];
                first <= 1'b0;
              end else begin
                bank[ptr] <= shift;
                wrpulse   <= 1'b1;
                wrindex   <= ptr;
                ptr       <= ptr + 1'b1;
              end
            end
          end
          S_WRACK: begin
            if (scl_fall) begin
              sdao  <= 1'b1;
              shift <= '0;
              st    <= S_WRBYTE;
            end
          end
          S_RDBYTE: begin
            // bit 7 went out on entry; the seven falls that follow shift out bits 6..0
            if (scl_fall) begin
              if (bitcnt == 4'd7) begin
                sdao <= 1'b1;
                st   <= S_RDACK;
              end else begin
                sdao   <= txbyte[6];
                txbyte <= {txbyte[6:0], 1'b0};
                bitcnt <= bitcnt + 4'd1;
              end
            end
          end
          S_RDACK: begin
            if (scl_rise) begin
              mack <= sdas;
            end else if (scl_fall) begin
              if (!mack) begin
                txbyte <= bank[ptr];
                sdao   <= bank[ptr][7];
                ptr    <= ptr + 1'b1;
                bitcnt <= '0;
                st     <= S_RDBYTE;
              end else begin
                sdao <= 1'b1;
                st   <= S_IGNORE;
              end
            end
          end
          S_IGNORE: sdao <= 1'b1;
          default:  sdao <= 1'b1;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_i2cresponder.sv
`timescale 1ns/1ps
// Bench for i2cresponder: bit-banged I2C master on a wired-AND SDA, host port driver,
// directed vector table, hand-built timing sequences and a random transaction phase.
// Expected bank contents come from a byte-array model of the register bank and pointer.
module tb_i2cresponder;
  logic       CLOCK = 1'b0;
  logic       RESET = 1'b1;
  logic       scl = 1'b1;
  logic       sda_m = 1'b1;
  logic       sdai;
  logic       sdao;
  logic [2:0] hostidx = 3'd0;
  logic [7:0] hostrdata;
  logic       hostwrite = 1'b0;
  logic [7:0] hostwdata = 8'd0;
  logic       wrpulse;
  logic [2:0] wrindex;
  logic       busy;
  logic [2:0] state;

  assign sdai = sda_m & sdao;

  i2cresponder #(.ADDR(7'h20), .NREGL2(3)) dut (
    .CLOCK(CLOCK), .RESET(RESET), .scli(scl), .sdai(sdai), .sdao(sdao),
    .hostidx(hostidx), .hostrdata(hostrdata), .hostwrite(hostwrite), .hostwdata(hostwdata),
    .wrpulse(wrpulse), .wrindex(wrindex), .busy(busy), .state(state)
  );

  always #5 CLOCK = ~CLOCK;

  int total = 0;
  int bad = 0;
  int wr_q[$];
  int low_cnt = 0;
  int busy_cnt = 0;

  // bus/side-band monitor, sampled on the falling clock edge
  always @(negedge CLOCK) begin
    if (wrpulse === 1'b1) wr_q.push_back(int'(wrindex));
    if (sdao === 1'b0) low_cnt++;
    if (busy === 1'b1) busy_cnt++;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: time limit reached, total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

  typedef struct {
    logic [6:0] addr;
    logic [7:0] idx;
    logic [7:0] wdata;
    logic       exp_ack;
    int         exp_wr;
    int         rd_idx;
    logic [7:0] rd_val;
  } vec_t;

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", nm, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin @(posedge CLOCK); #1; end
  endtask

  function automatic int qat(input int i);
    return (i < wr_q.size()) ? wr_q[i] : -1;
  endfunction

  task automatic clk_bit(input logic b, output logic r);
    sda_m = b; tick(5);
    scl = 1'b1; tick(3);
    r = sdai; tick(3);
    scl = 1'b0; tick(1);
  endtask

  task automatic i2c_start;
    sda_m = 1'b1; tick(5);
    scl = 1'b1; tick(5);
    sda_m = 1'b0; tick(5);
    scl = 1'b0; tick(1);
  endtask

  task automatic i2c_stop;
    sda_m = 1'b0; tick(5);
    scl = 1'b1; tick(5);
    sda_m = 1'b1; tick(5);
  endtask

  task automatic wr_byte(input logic [7:0] b, output logic ack);
    logic r;
    for (int i = 7; i >= 0; i--) clk_bit(b[i], r);
    clk_bit(1'b1, r);
    ack = ~r;
  endtask

  task automatic rd_byte(input logic nack, output logic [7:0] b);
    logic r;
    for (int i = 7; i >= 0; i--) begin clk_bit(1'b1, r); b[i] = r; end
    clk_bit(nack, r);
  endtask

  task automatic host_wr(input int i, input logic [7:0] d);
    hostidx = i[2:0]; hostwdata = d; hostwrite = 1'b1; tick(1); hostwrite = 1'b0;
  endtask

  task automatic host_rd(input int i, output logic [7:0] d);
    hostidx = i[2:0]; #1; d = hostrdata;
  endtask

  // count CLOCK edges until sdao reaches the target level
  task automatic meas(input logic target, output int n);
    n = 0;
    for (int k = 0; k < 10; k++) begin
      tick(1); n++;
      if (sdao === target) break;
    end
  endtask

  initial begin
    vec_t       tbl[7];
    logic [7:0] mbank[8];
    int         mptr;
    logic       a0, a1, a2, a3, r;
    logic [7:0] b0, b1, b2, v;
    int         base, l0, bz0, n, nak;
    int         exp_wr[$];

    tbl[0] = '{7'h20, 8'h01, 8'hC3, 1'b1,  1, 1, 8'hC3};
    tbl[1] = '{7'h21, 8'h01, 8'h5A, 1'b0, -1, 1, 8'hC3};
    tbl[2] = '{7'h20, 8'h0E, 8'h7E, 1'b1,  6, 6, 8'h7E};
    tbl[3] = '{7'h00, 8'h02, 8'h11, 1'b0, -1, 2, 8'h00};
    tbl[4] = '{7'h20, 8'hFF, 8'h80, 1'b1,  7, 7, 8'h80};
    tbl[5] = '{7'h10, 8'h07, 8'h01, 1'b0, -1, 7, 8'h80};
    tbl[6] = '{7'h20, 8'h00, 8'h01, 1'b1,  0, 0, 8'h01};

    // reset state
    RESET = 1'b1; tick(6);
    RESET = 1'b0; tick(2);
    chk("rst sdao", sdao, 1);
    chk("rst busy", busy, 0);
    chk("rst wrpulse", wrpulse, 0);
    chk("rst wrindex", wrindex, 0);
    chk("rst state", state, 0);
    for (int i = 0; i < 8; i++) begin host_rd(i, v); chk("rst bank", v, 0); end

    // directed vector table: one address + index + data write each, then host readback
    for (int t = 0; t < 7; t++) begin
      base = wr_q.size();
      i2c_start;
      wr_byte({tbl[t].addr, 1'b0}, a0);
      wr_byte(tbl[t].idx, a1);
      wr_byte(tbl[t].wdata, a2);
      i2c_stop;
      chk("tbl acks", {a0, a1, a2}, tbl[t].exp_ack ? 3'b111 : 3'b000);
      chk("tbl wrcount", wr_q.size() - base, tbl[t].exp_ack ? 1 : 0);
      chk("tbl wrindex", qat(base), tbl[t].exp_wr);
      host_rd(tbl[t].rd_idx, v);
      chk("tbl readback", v, tbl[t].rd_val);
    end

    // write sequence: 0x40 0x02 0xA5 0x3C
    base = wr_q.size(); bz0 = busy_cnt;
    i2c_start;
    wr_byte(8'h40, a0); wr_byte(8'h02, a1); wr_byte(8'hA5, a2); wr_byte(8'h3C, a3);
    chk("wr busy mid", busy, 1);
    i2c_stop; tick(2);
    chk("wr acks", {a0, a1, a2, a3}, 4'b1111);
    chk("wr busy after stop", busy, 0);
    chk("wr busy seen", busy_cnt > bz0, 1);
    chk("wr pulses", wr_q.size() - base, 2);
    chk("wr idx0", qat(base), 2);
    chk("wr idx1", qat(base + 1), 3);
    host_rd(2, v); chk("wr bank2", v, 8'hA5);
    host_rd(3, v); chk("wr bank3", v, 8'h3C);

    // ADDRACK latency: 8th address fall -> sdao low, ack fall -> sdao released
    i2c_start;
    for (int i = 7; i >= 1; i--) clk_bit(1'(8'h40 >> i), r);
    sda_m = 1'b0; tick(5); scl = 1'b1; tick(6); scl = 1'b0;
    meas(1'b0, n); chk("lat ack drive", n, 3);
    tick(2); scl = 1'b1; tick(6); scl = 1'b0;
    meas(1'b1, n); chk("lat ack release", n, 3);
    tick(2);
    i2c_stop;

    // read with repeated start and pointer wrap 7 -> 0
    host_wr(6, 8'h11); host_wr(7, 8'h22); host_wr(0, 8'h33);
    i2c_start;
    wr_byte(8'h40, a0); wr_byte(8'h06, a1);
    i2c_start;
    wr_byte(8'h41, a2);
    rd_byte(1'b0, b0); rd_byte(1'b0, b1); rd_byte(1'b1, b2);
    l0 = low_cnt;
    clk_bit(1'b1, r); clk_bit(1'b1, r);
    chk("rd acks", {a0, a1, a2}, 3'b111);
    chk("rd byte0", b0, 8'h11);
    chk("rd byte1", b1, 8'h22);
    chk("rd byte2", b2, 8'h33);
    chk("rd after nack low", low_cnt - l0, 0);
    chk("rd ignore state", state, 7);
    i2c_stop; tick(2);
    chk("rd idle after stop", state, 0);

    // wrong address
    base = wr_q.size(); l0 = low_cnt; bz0 = busy_cnt;
    i2c_start; wr_byte(8'h42, a0); wr_byte(8'hFF, a1); i2c_stop;
    chk("wa acks", {a0, a1}, 2'b00);
    chk("wa sdao low", low_cnt - l0, 0);
    chk("wa busy", busy_cnt - bz0, 0);
    chk("wa pulses", wr_q.size() - base, 0);

    // reset while the target drives bit 4 of a 0x00 byte
    i2c_start; wr_byte(8'h40, a0); wr_byte(8'h04, a1); i2c_stop;
    i2c_start; wr_byte(8'h41, a2);
    chk("rr acks", {a0, a1, a2}, 3'b111);
    for (int i = 0; i < 3; i++) clk_bit(1'b1, r);
    sda_m = 1'b1; tick(5);
    chk("rr drive before reset", sdao, 0);
    RESET = 1'b1; tick(1);
    chk("rr sdao", sdao, 1);
    chk("rr state", state, 0);
    chk("rr busy", busy, 0);
    RESET = 1'b0;
    scl = 1'b1; tick(6); scl = 1'b0; tick(1);
    l0 = low_cnt;
    for (int i = 0; i < 3; i++) clk_bit(1'b1, r);
    chk("rr quiet", low_cnt - l0, 0);
    chk("rr stays idle", state, 0);
    i2c_stop;
    host_rd(2, v); chk("rr bank cleared", v, 0);
    i2c_start; wr_byte(8'h40, a0); wr_byte(8'h05, a1); wr_byte(8'h77, a2); i2c_stop;
    chk("rr write acks", {a0, a1, a2}, 3'b111);
    host_rd(5, v); chk("rr write bank5", v, 8'h77);

    // host/I2C collision on index 1, plus wrpulse timing from the 8th fall
    i2c_start; wr_byte(8'h40, a0); wr_byte(8'h01, a1);
    for (int i = 7; i >= 1; i--) clk_bit(1'(8'h99 >> i), r);
    sda_m = 1'b1; tick(5); scl = 1'b1; tick(6); scl = 1'b0;
    tick(2);
    chk("coll pulse early", wrpulse, 0);
    hostidx = 3'd1; hostwdata = 8'h55; hostwrite = 1'b1;
    tick(1);
    hostwrite = 1'b0;
    chk("coll pulse", wrpulse, 1);
    chk("coll wrindex", wrindex, 1);
    tick(1);
    chk("coll pulse width", wrpulse, 0);
    tick(2); scl = 1'b1; tick(3); r = sdai; tick(3); scl = 1'b0; tick(1);
    i2c_stop;
    chk("coll acks", {a0, a1, ~r}, 3'b111);
    host_rd(1, v); chk("coll bank1", v, 8'h99);

    // random transactions against the bank/pointer model
    RESET = 1'b1; tick(3); RESET = 1'b0; tick(2);
    for (int i = 0; i < 8; i++) mbank[i] = 8'h00;
    mptr = 0;
    for (int it = 0; it < 30; it++) begin
      case ($urandom_range(0, 3))
        0: begin
          n = $urandom_range(0, 7); v = 8'($urandom);
          host_wr(n, v); mbank[n] = v;
        end
        1: begin
          base = wr_q.size(); exp_wr.delete(); nak = 0;
          n = $urandom_range(1, 4);
          i2c_start;
          wr_byte(8'h40, a0); nak += int'(!a0);
          b0 = 8'($urandom); wr_byte(b0, a0); nak += int'(!a0);
          mptr = b0 % 8;
          for (int k = 1; k < n; k++) begin
            b1 = 8'($urandom); wr_byte(b1, a0); nak += int'(!a0);
            exp_wr.push_back(mptr); mbank[mptr] = b1; mptr = (mptr + 1) % 8;
          end
          i2c_stop;
          chk("rnd wr nacks", nak, 0);
          chk("rnd wr pulses", wr_q.size() - base, exp_wr.size());
          foreach (exp_wr[k]) chk("rnd wr index", qat(base + k), exp_wr[k]);
        end
        2: begin
          n = $urandom_range(1, 3);
          i2c_start; wr_byte(8'h41, a0);
          chk("rnd rd addr ack", a0, 1);
          for (int k = 0; k < n; k++) begin
            rd_byte(k == n - 1, b0);
            chk("rnd rd data", b0, mbank[mptr]);
            mptr = (mptr + 1) % 8;
          end
          i2c_stop;
        end
        default: begin
          base = wr_q.size(); l0 = low_cnt;
          b0 = 8'($urandom_range(0, 255));
          if (b0[7:1] == 7'h20) b0[7:1] = 7'h21;
          i2c_start; wr_byte(b0, a0); wr_byte(8'($urandom), a1); i2c_stop;
          chk("rnd wa nack", {a0, a1}, 2'b00);
          chk("rnd wa quiet", (low_cnt - l0) + (wr_q.size() - base), 0);
        end
      endcase
    end
    for (int i = 0; i < 8; i++) begin
      host_rd(i, v);
      chk("rnd final bank", v, mbank[i]);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
